regfile_scoreboard: RTL and testbench

Parametrised general-purpose register file for the pipelined core. It has NUM_RD combinational read ports with same-cycle write-through bypass, one synchronous write (writeback) port, and an optional hardwired-zero register. A per-register busy scoreboard tracks in-flight producers (loads, multi-cycle ops) and raises a stall to the decode stage on read-after-write hazards.

---
 rtl/regfile_scoreboard.sv | 137 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   General-purpose register file for the pipelined core, with a scoreboard that
//   tracks destination registers of in-flight producers (loads, multi-cycle ops).
//
//   Ports
//     clk       in   system clock, rising edge
//     rst       in   asynchronous active-high reset (registers, busy bits, count)
//     raddr     in   NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//     ren       in   operand k actually used (only qualifies stall)
//     rdata     out  NUM_RD packed read data, combinational, write-through bypass
//     rbusy     out  operand k has an outstanding producer (combinational)
//     stall     out  OR over k of (ren[k] & rbusy[k])
//     we        in   writeback enable
//     waddr     in   writeback address
//     wdata     in   writeback data
//     set_en    in   issue of a multi-cycle producer, marks set_addr busy
//     set_addr  in   destination register of the issued producer
//     flush     in   clears every busy bit (overrides a same-cycle set_en)
//     busy_cnt  out  registered number of busy registers
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    input  logic [NUM_RD-1:0]        ren,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    output logic                     stall,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int   DEPTH = 32'd1 << ADDR_W;
    localparam logic ZR    = 1'(ZERO_REG);

    logic [DATA_W-1:0]        regs_q [DEPTH];
    logic [DEPTH-1:0]         busy_q;
    logic [DEPTH-1:0]         busy_d;
    logic [ADDR_W:0]          busy_cnt_q;
    logic [ADDR_W:0]          busy_cnt_d;

    logic                     wr_ok_s;
    logic                     set_ok_s;
    logic [DEPTH-1:0]         one_hot_s;
    logic [DEPTH-1:0]         clr_mask_s;
    logic [DEPTH-1:0]         set_mask_s;
    logic [NUM_RD*DATA_W-1:0] rdata_s;
    logic [NUM_RD-1:0]        rbusy_s;

    // Number of ones in a busy vector.
    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Register 0 is hardwired when ZR is set: it never accepts data or a busy mark.
    assign wr_ok_s   = we && !(ZR && (waddr == '0));
    assign set_ok_s  = set_en && !(ZR && (set_addr == '0));
    assign one_hot_s = {{(DEPTH-1){1'b0}}, 1'b1};

    // Scoreboard next state: flush dominates; a set is OR-ed in after the writeback
    // clear so a new producer on the same register supersedes the retiring one.
    always_comb begin
        clr_mask_s = we       ? (one_hot_s << waddr)    : '0;
        set_mask_s = set_ok_s ? (one_hot_s << set_addr) : '0;
        busy_d     = flush ? '0 : ((busy_q & ~clr_mask_s) | set_mask_s);
        busy_cnt_d = popcount(busy_d);
    end

    // Register storage with writeback port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok_s) begin
            regs_q[waddr] <= wdata;
        end else begin
            regs_q[waddr] <= regs_q[waddr];
        end
    end

    // Busy bits and their registered population count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Read ports: hardwired zero, then same-cycle writeback bypass, then storage.
    // A bypassed writeback also resolves the hazard for that operand.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic              zero_hit;
        logic              byp_hit;
        rdata_s = '0;
        rbusy_s = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra       = raddr[k*ADDR_W +: ADDR_W];
            zero_hit = ZR && (ra == '0);
            byp_hit  = we && (waddr == ra);
            if (zero_hit) begin
                rdata_s[k*DATA_W +: DATA_W] = '0;
            end else if (byp_hit) begin
                rdata_s[k*DATA_W +: DATA_W] = wdata;
            end else begin
                rdata_s[k*DATA_W +: DATA_W] = regs_q[ra];
            end
            rbusy_s[k] = busy_q[ra] & ~byp_hit & ~zero_hit;
        end
    end

    assign rdata    = rdata_s;
    assign rbusy    = rbusy_s;
    assign stall    = |(ren & rbusy_s);
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios on a ZERO_REG=1
// instance (with a ZERO_REG=0 twin sharing all inputs), then random traffic
// compared against an array-based reference model of both variants.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [9:0]  raddr;
    logic [1:0]  ren;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        set_en;
    logic [4:0]  set_addr;
    logic        flush;

    logic [63:0] rdata_z, rdata_nz;
    logic [1:0]  rbusy_z, rbusy_nz;
    logic        stall_z, stall_nz;
    logic [5:0]  cnt_z, cnt_nz;

    int errors = 0;
    int checks = 0;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .raddr(raddr), .ren(ren), .rdata(rdata_z),
        .rbusy(rbusy_z), .stall(stall_z), .we(we), .waddr(waddr), .wdata(wdata),
        .set_en(set_en), .set_addr(set_addr), .flush(flush), .busy_cnt(cnt_z));

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_nz (
        .clk(clk), .rst(rst), .raddr(raddr), .ren(ren), .rdata(rdata_nz),
        .rbusy(rbusy_nz), .stall(stall_nz), .we(we), .waddr(waddr), .wdata(wdata),
        .set_en(set_en), .set_addr(set_addr), .flush(flush), .busy_cnt(cnt_nz));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; set_en = 1'b0; flush = 1'b0;
        waddr = 5'd0; wdata = 32'd0; set_addr = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); raddr = {5'd7, 5'd5}; ren = 2'b11;
        tick(); #1;
        checks++; if (rdata_z[31:0] !== 32'd0) begin errors++; $display("FAIL reset_rdata0 got=%h exp=0", rdata_z[31:0]); end
        checks++; if (cnt_z !== 6'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt_z); end
        checks++; if (stall_z !== 1'b0 || rbusy_z !== 2'b00) begin errors++; $display("FAIL reset_stall got=%b/%b exp=0/00", stall_z, rbusy_z); end
        rst = 1'b0; tick();
    endtask

    task automatic test_write_bypass();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd7, 5'd5}; #1;
        checks++; if (rdata_z[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_r5 got=%h exp=deadbeef", rdata_z[31:0]); end
        tick(); idle(); #1;
        checks++; if (rdata_z[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_r5 got=%h exp=deadbeef", rdata_z[31:0]); end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234; set_en = 1'b1; set_addr = 5'd0;
        raddr = {5'd5, 5'd0}; #1;
        checks++; if (rdata_z[31:0] !== 32'd0 || rbusy_z[0] !== 1'b0) begin errors++; $display("FAIL zero_bypass got=%h/%b exp=0/0", rdata_z[31:0], rbusy_z[0]); end
        tick(); idle(); #1;
        checks++; if (rdata_z[31:0] !== 32'd0 || rbusy_z[0] !== 1'b0 || cnt_z !== 6'd0) begin errors++; $display("FAIL zero_r0 got=%h/%b/%0d exp=0/0/0", rdata_z[31:0], rbusy_z[0], cnt_z); end
        checks++; if (rdata_nz[31:0] !== 32'h1234 || rbusy_nz[0] !== 1'b1 || cnt_nz !== 6'd1) begin errors++; $display("FAIL nonzero_r0 got=%h/%b/%0d exp=1234/1/1", rdata_nz[31:0], rbusy_nz[0], cnt_nz); end
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234; tick(); idle(); #1;
        checks++; if (cnt_nz !== 6'd0) begin errors++; $display("FAIL nonzero_r0_clear got=%0d exp=0", cnt_nz); end
    endtask

    task automatic test_scoreboard();
        set_en = 1'b1; set_addr = 5'd7; tick(); idle(); #1;
        checks++; if (cnt_z !== 6'd1) begin errors++; $display("FAIL sb_cnt_set got=%0d exp=1", cnt_z); end
        raddr = {5'd5, 5'd7}; ren = 2'b01; #1;
        checks++; if (stall_z !== 1'b1) begin errors++; $display("FAIL sb_stall got=%b exp=1", stall_z); end
        ren = 2'b00; #1;
        checks++; if (stall_z !== 1'b0 || rbusy_z[0] !== 1'b1) begin errors++; $display("FAIL sb_ren0 got=%b/%b exp=0/1", stall_z, rbusy_z[0]); end
        ren = 2'b01; we = 1'b1; waddr = 5'd7; wdata = 32'h55; #1;
        checks++; if (stall_z !== 1'b0 || rdata_z[31:0] !== 32'h55) begin errors++; $display("FAIL sb_wb got=%b/%h exp=0/55", stall_z, rdata_z[31:0]); end
        tick(); idle(); #1;
        checks++; if (cnt_z !== 6'd0) begin errors++; $display("FAIL sb_cnt_clear got=%0d exp=0", cnt_z); end
    endtask

    task automatic test_simultaneous();
        set_en = 1'b1; set_addr = 5'd3; tick();
        we = 1'b1; waddr = 5'd3; wdata = 32'h33; tick(); idle();
        raddr = {5'd9, 5'd3}; #1;
        checks++; if (cnt_z !== 6'd1 || rbusy_z[0] !== 1'b1) begin errors++; $display("FAIL sim_same got=%0d/%b exp=1/1", cnt_z, rbusy_z[0]); end
        we = 1'b1; waddr = 5'd3; set_en = 1'b1; set_addr = 5'd9; tick(); idle(); #1;
        checks++; if (cnt_z !== 6'd1 || rbusy_z !== 2'b10) begin errors++; $display("FAIL sim_diff got=%0d/%b exp=1/10", cnt_z, rbusy_z); end
        we = 1'b1; waddr = 5'd9; tick(); idle();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_en = 1'b1; set_addr = (i == 2) ? 5'd4 : 5'(i + 1); tick();
        end
        idle(); #1;
        checks++; if (cnt_z !== 6'd3) begin errors++; $display("FAIL flush_pre got=%0d exp=3", cnt_z); end
        flush = 1'b1; set_en = 1'b1; set_addr = 5'd6; tick(); idle();
        raddr = {5'd6, 5'd1}; #1;
        checks++; if (cnt_z !== 6'd0 || rbusy_z !== 2'b00) begin errors++; $display("FAIL flush_post got=%0d/%b exp=0/00", cnt_z, rbusy_z); end
        raddr = {5'd7, 5'd5}; #1;
        checks++; if (rdata_z !== {32'h55, 32'hDEADBEEF}) begin errors++; $display("FAIL flush_data got=%h exp=00000055deadbeef", rdata_z); end
    endtask

    task automatic test_async_reset();
        we = 1'b1; waddr = 5'd10; wdata = 32'hA5A5A5A5; tick(); idle();
        set_en = 1'b1; set_addr = 5'd11; tick(); idle();
        raddr = {5'd11, 5'd10}; #1;
        checks++; if (rdata_z[31:0] !== 32'hA5A5A5A5 || rbusy_z[1] !== 1'b1) begin errors++; $display("FAIL ar_pre got=%h/%b exp=a5a5a5a5/1", rdata_z[31:0], rbusy_z[1]); end
        rst = 1'b1; we = 1'b1; waddr = 5'd12; wdata = 32'hFFFF0000; #1;
        checks++; if (rdata_z[31:0] !== 32'd0 || rbusy_z !== 2'b00 || cnt_z !== 6'd0) begin errors++; $display("FAIL ar_now got=%h/%b/%0d exp=0/00/0", rdata_z[31:0], rbusy_z, cnt_z); end
        tick(); rst = 1'b0; idle(); raddr = {5'd11, 5'd12}; #1;
        checks++; if (rdata_z[31:0] !== 32'd0) begin errors++; $display("FAIL ar_no_write got=%h exp=0", rdata_z[31:0]); end
    endtask

    // Reference model: one storage array and busy array per ZERO_REG variant.
    logic [31:0] m_reg  [2][32];
    bit          m_busy [2][32];

    task automatic test_random();
        logic [31:0] e_data, g_data;
        bit          e_busy, zhit, bhit;
        int          e_cnt;
        logic [4:0]  ra;
        rst = 1'b1; idle(); tick(); rst = 1'b0;
        for (int z = 0; z < 2; z++)
            for (int a = 0; a < 32; a++) begin m_reg[z][a] = 32'd0; m_busy[z][a] = 1'b0; end
        for (int it = 0; it < 400; it++) begin
            raddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            ren      = 2'($urandom);
            we       = ($urandom_range(0, 1) == 0);
            waddr    = 5'($urandom_range(0, 7));
            wdata    = $urandom;
            set_en   = ($urandom_range(0, 2) == 0);
            set_addr = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 19) == 0);
            #1;
            for (int z = 0; z < 2; z++) begin
                bit e_stall;
                e_stall = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    ra   = raddr[k*5 +: 5];
                    zhit = (z == 1) && (ra == 5'd0);
                    bhit = we && (waddr == ra);
                    e_data = zhit ? 32'd0 : (bhit ? wdata : m_reg[z][ra]);
                    e_busy = m_busy[z][ra] && !bhit && !zhit;
                    if (ren[k] && e_busy) e_stall = 1'b1;
                    g_data = (z == 1) ? rdata_z[k*32 +: 32] : rdata_nz[k*32 +: 32];
                    checks++; if (g_data !== e_data) begin errors++; $display("FAIL rnd_rdata z=%0d k=%0d it=%0d got=%h exp=%h", z, k, it, g_data, e_data); end
                    checks++; if (((z == 1) ? rbusy_z[k] : rbusy_nz[k]) !== e_busy) begin errors++; $display("FAIL rnd_rbusy z=%0d k=%0d it=%0d exp=%b", z, k, it, e_busy); end
                end
                checks++; if (((z == 1) ? stall_z : stall_nz) !== e_stall) begin errors++; $display("FAIL rnd_stall z=%0d it=%0d exp=%b", z, it, e_stall); end
                // Spec rules applied at the clock edge.
                if (we && !((z == 1) && waddr == 5'd0)) m_reg[z][waddr] = wdata;
                if (flush) begin
                    for (int a = 0; a < 32; a++) m_busy[z][a] = 1'b0;
                end else begin
                    if (we) m_busy[z][waddr] = 1'b0;
                    if (set_en && !((z == 1) && set_addr == 5'd0)) m_busy[z][set_addr] = 1'b1;
                end
            end
            tick();
            for (int z = 0; z < 2; z++) begin
                e_cnt = 0;
                for (int a = 0; a < 32; a++) e_cnt += m_busy[z][a];
                checks++; if (((z == 1) ? cnt_z : cnt_nz) !== 6'(e_cnt)) begin errors++; $display("FAIL rnd_cnt z=%0d it=%0d got=%0d exp=%0d", z, it, (z == 1) ? cnt_z : cnt_nz, e_cnt); end
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1; raddr = '0; ren = '0; idle();
        test_reset();
        test_write_bypass();
        test_zero_reg();
        test_scoreboard();
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
